elevator_request_scheduler: RTL and testbench
=============================================

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NFLOORS, default 8, number of floors (one-hot width).
REQ-002 SHALL have parameter DOOR_TICKS, default 4, door dwell length in tick pulses.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, button synchronizer depth.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn  input  NFLOORS  raw asynchronous floor-request buttons, bit i = floor i+1.
REQ-007 cur_floor  input  NFLOORS  one-hot current floor from the downstream car-motion stage.
REQ-008 tick  input  1  single-cycle scheduling strobe, aligned with the downstream car step.
REQ-009 target  output  NFLOORS  one-hot floor the downstream stage drives toward; 0 = no target.
REQ-010 pending  output  NFLOORS  latched outstanding requests.
REQ-011 dir_up  output  1  scan direction, 1 = up.
REQ-012 door_open  output  1  high while in DOOR state.
REQ-013 fault  output  1  sticky flag: cur_floor was not one-hot on a tick.

Function
REQ-014 Each btn bit SHALL pass through SYNC_STAGES flops plus one edge register; pending[i] SHALL set exactly SYNC_STAGES+1 cycles after btn[i] rises; held buttons SHALL set at most once per press.
REQ-015 State machine SHALL have states IDLE, MOVE, DOOR; all transitions evaluated only on cycles with tick=1, except request capture (every cycle).
REQ-016 IDLE: target=0; on tick, if pending & cur_floor != 0 -> DOOR; else if pending != 0 -> MOVE; else stay.
REQ-017 MOVE: on tick, if pending & cur_floor != 0 -> DOOR; else hold MOVE.
REQ-018 DOOR: entry SHALL clear pending bit of cur_floor and load dwell counter with DOOR_TICKS; counter decrements per tick; at 0 -> MOVE if pending != 0, else IDLE.
REQ-019 Press of cur_floor while in DOOR SHALL not set pending and SHALL reload the dwell counter to DOOR_TICKS.
REQ-020 Target selection (MOVE, combinational from registered state): dir_up=1 -> lowest pending bit above cur_floor; dir_up=0 -> highest pending bit below cur_floor.
REQ-021 If no pending bit exists in the current direction on a tick in MOVE/IDLE exit, dir_up SHALL invert on that tick and target SHALL reflect the new direction from the next cycle.
REQ-022 target SHALL always be one-hot or zero; target SHALL be 0 in IDLE and DOOR.
REQ-023 Simultaneous set and clear of the same pending bit in one cycle: clear wins.
REQ-024 Boundaries: at top floor dir_up SHALL be forced to 0, at floor 1 forced to 1, on the tick they are reached.
REQ-025 If cur_floor is not one-hot on a tick: fault SHALL set, state/dir/counter SHALL hold, pending capture continues.
REQ-026 tick asserted in consecutive cycles SHALL be honoured each cycle (no internal rate limit).

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, pending=0, target=0, dir_up=1, door_open=0, fault=0, dwell counter=0, synchronizer/edge flops=0.
REQ-028 Reset mid-DOOR or mid-MOVE SHALL discard all requests; buttons held across reset release SHALL not register (edge flops see high as prior).

Structure
REQ-029 Package elevator_pkg SHALL hold NFLOORS default, DOOR_TICKS default, state enum {IDLE, MOVE, DOOR}, and one-hot helper functions (is_onehot, lowest_above, highest_below).
REQ-030 Sub-module btn_sync_edge (per-bit SYNC_STAGES synchronizer + rising-edge pulse) SHALL be instantiated once, NFLOORS wide.
REQ-031 Target selection SHALL be combinational from registered pending/cur_floor/dir_up; no latches.

Verification
REQ-032 Reset, cur_floor=0x01, pulse btn=0x10 -> pending=0x10 three cycles later; next tick -> MOVE, target=0x10, dir_up=1.
REQ-033 cur_floor=0x08, dir_up=1, pending=0x41 -> target=0x40; after car reaches 0x40 and dwell, target=0x01 with dir_up=0.
REQ-034 Arrive at 0x10 with pending=0x10 -> DOOR, door_open=1, pending=0, exactly 4 ticks later IDLE, door_open=0.
REQ-035 In DOOR at 0x04, press btn[2] after 2 ticks -> pending stays 0, door stays open 4 further ticks.
REQ-036 cur_floor=0x06 on a tick -> fault=1 sticky, state unchanged; rst=1 -> fault=0, pending=0, IDLE.
REQ-037 Hold btn=0xFF across rst deassert -> pending stays 0; release and re-press btn[7] -> pending=0x80.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler.
//   - Default parameter values (floor count, door dwell length).
//   - Scheduler state encoding.
//   - One-hot helpers. They work on a fixed MAX_FLOORS-wide vector, so any
//     NFLOORS up to MAX_FLOORS is zero-extended into them. Every result is
//     either one-hot or zero.
package elevator_pkg;

    localparam int NFLOORS_DEF    = 8;
    localparam int DOOR_TICKS_DEF = 4;
    localparam int MAX_FLOORS     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef logic [MAX_FLOORS-1:0] floor_vec_t;

    function automatic logic is_onehot(input floor_vec_t v);
        return (v != '0) && ((v & (v - floor_vec_t'(1))) == '0);
    endfunction

    // Lowest set bit of p strictly above the floor c.
    function automatic floor_vec_t lowest_above(input floor_vec_t p, input floor_vec_t c);
        floor_vec_t m;
        m = p & ~(c | (c - floor_vec_t'(1)));
        return m & (~m + floor_vec_t'(1));
    endfunction

    // Highest set bit of p strictly below the floor c.
    function automatic floor_vec_t highest_below(input floor_vec_t p, input floor_vec_t c);
        floor_vec_t m;
        floor_vec_t r;
        m = p & (c - floor_vec_t'(1));
        r = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (m[i]) begin
                r = floor_vec_t'(1) << i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_request_scheduler_btn_sync_edge.sv
// Per-bit button synchronizer plus rising-edge detector.
//   clk, rst : clock and synchronous active-high reset
//   btn_i    : raw asynchronous buttons
//   pulse_o  : one-cycle pulse per press, STAGES cycles after btn_i rises
// A bit is only armed once its synchronized level has been seen low after
// reset, so a button held through reset release never produces a pulse.
// As a consequence, a press that is already high on the first sample after
// reset is treated as held and ignored until it is released.
module btn_sync_edge #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] pulse_o
);

    // Marks when the synchronizer chain holds real samples rather than
    // reset zeros; a zero in that window must not arm a bit.
    logic [STAGES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q << 1) | STAGES'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [STAGES-1:0] sync_q;
            logic              prev_q;
            logic              armed_q;
            logic              sync_out;

            assign sync_out = sync_q[STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q  <= '0;
                    prev_q  <= 1'b0;
                    armed_q <= 1'b0;
                end else begin
                    sync_q <= (sync_q << 1) | STAGES'(btn_i[gi]);
                    prev_q <= sync_out;
                    if (valid_q[STAGES-1] && !sync_out) begin
                        armed_q <= 1'b1;
                    end
                end
            end

            assign pulse_o[gi] = sync_out & ~prev_q & armed_q;
        end
    endgenerate

endmodule

// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches floor requests and scans them with a
// SCAN (elevator) policy, issuing one target floor at a time.
//   clk, rst   : clock, synchronous active-high reset
//   btn        : raw floor buttons (bit i = floor i+1)
//   cur_floor  : one-hot current floor from the car-motion stage
//   tick       : scheduling strobe; state/direction/dwell only move on it
//   target     : one-hot floor to drive toward, 0 when none
//   pending    : latched outstanding requests
//   dir_up     : scan direction (1 = up)
//   door_open  : high while in DOOR
//   fault      : sticky, set when cur_floor is not one-hot on a tick
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NFLOORS     = NFLOORS_DEF,
    parameter int DOOR_TICKS  = DOOR_TICKS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] btn,
    input  logic [NFLOORS-1:0] cur_floor,
    input  logic               tick,
    output logic [NFLOORS-1:0] target,
    output logic [NFLOORS-1:0] pending,
    output logic               dir_up,
    output logic               door_open,
    output logic               fault
);

    localparam int CW = $clog2(DOOR_TICKS + 1);

    state_t             state_q;
    logic [NFLOORS-1:0] pending_q;
    logic [NFLOORS-1:0] pending_d;
    logic [NFLOORS-1:0] cur_q;
    logic               dir_q;
    logic               door_q;
    logic               fault_q;
    logic [CW-1:0]      cnt_q;

    logic [NFLOORS-1:0] press;
    logic [NFLOORS-1:0] set_mask;
    logic [NFLOORS-1:0] clr_mask;
    logic               cur_valid;
    logic               at_floor;
    logic               door_entry;
    logic               door_press;
    logic               dir_b;
    logic               more_in_dir;
    logic               dir_mv;

    btn_sync_edge #(
        .WIDTH  (NFLOORS),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .pulse_o (press)
    );

    assign cur_valid  = is_onehot(floor_vec_t'(cur_floor));
    assign at_floor   = |(pending_q & cur_floor);
    assign door_entry = tick && cur_valid && (state_q != DOOR) && at_floor;
    // A press of the floor we are standing at only keeps the door open.
    assign door_press = (state_q == DOOR) && |(press & cur_floor);

    assign set_mask  = (state_q == DOOR) ? (press & ~cur_floor) : press;
    assign clr_mask  = door_entry ? cur_floor : '0;
    assign pending_d = (pending_q | set_mask) & ~clr_mask;

    // End floors force the direction before the "anything ahead?" check.
    assign dir_b = cur_floor[NFLOORS-1] ? 1'b0 : (cur_floor[0] ? 1'b1 : dir_q);

    always_comb begin
        more_in_dir = 1'b0;
        if (dir_b) begin
            more_in_dir = |lowest_above(floor_vec_t'(pending_q), floor_vec_t'(cur_floor));
        end else begin
            more_in_dir = |highest_below(floor_vec_t'(pending_q), floor_vec_t'(cur_floor));
        end
    end

    // Direction used whenever the next state is MOVE: turn around if
    // nothing is pending ahead.
    assign dir_mv = more_in_dir ? dir_b : ~dir_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            dir_q     <= 1'b1;
            door_q    <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cur_q     <= cur_floor;
            if (tick && cur_valid) begin
                dir_q <= dir_b;
                case (state_q)
                    IDLE, MOVE: begin
                        if (at_floor) begin
                            state_q <= DOOR;
                            door_q  <= 1'b1;
                            cnt_q   <= CW'(DOOR_TICKS);
                        end else if (pending_q != '0) begin
                            state_q <= MOVE;
                            dir_q   <= dir_mv;
                        end
                    end
                    DOOR: begin
                        if (door_press) begin
                            cnt_q <= CW'(DOOR_TICKS);
                        end else if (cnt_q <= CW'(1)) begin
                            cnt_q  <= '0;
                            door_q <= 1'b0;
                            if (pending_q != '0) begin
                                state_q <= MOVE;
                                dir_q   <= dir_mv;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        door_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                endcase
            end else begin
                // Bad floor code on a tick: flag it and freeze scheduling.
                if (tick) begin
                    fault_q <= 1'b1;
                end
                if (door_press) begin
                    cnt_q <= CW'(DOOR_TICKS);
                end
            end
        end
    end

    always_comb begin
        target = '0;
        if (state_q == MOVE) begin
            if (dir_q) begin
                target = NFLOORS'(lowest_above(floor_vec_t'(pending_q), floor_vec_t'(cur_q)));
            end else begin
                target = NFLOORS'(highest_below(floor_vec_t'(pending_q), floor_vec_t'(cur_q)));
            end
        end
    end

    assign pending   = pending_q;
    assign dir_up    = dir_q;
    assign door_open = door_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
module tb_elevator_request_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] btn;
    logic [7:0] cur_floor;
    logic       tick;
    logic [7:0] target;
    logic [7:0] pending;
    logic       dir_up;
    logic       door_open;
    logic       fault;

    int n_tests;
    int n_fail;

    elevator_request_scheduler #(
        .NFLOORS     (8),
        .DOOR_TICKS  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .cur_floor (cur_floor),
        .tick      (tick),
        .target    (target),
        .pending   (pending),
        .dir_up    (dir_up),
        .door_open (door_open),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cur;
        logic [7:0] btn;
        int         ticks;
        logic [7:0] pend;
        logic [7:0] tgt;
        logic       dir;
        logic       door;
    } vec_t;

    vec_t vecs[26];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] b);
        btn = b;
        @(negedge clk);
        btn = 8'h00;
        cyc(3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //          cur    btn    tk  pend   tgt    dir   door
        vecs[0]  = '{8'h01, 8'h10, 0, 8'h10, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{8'h01, 8'h00, 1, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[2]  = '{8'h02, 8'h00, 1, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[3]  = '{8'h04, 8'h00, 1, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[4]  = '{8'h08, 8'h00, 1, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[5]  = '{8'h10, 8'h00, 1, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{8'h10, 8'h00, 3, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{8'h10, 8'h00, 1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{8'h08, 8'h41, 0, 8'h41, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h08, 8'h00, 1, 8'h41, 8'h40, 1'b1, 1'b0};
        vecs[10] = '{8'h10, 8'h00, 1, 8'h41, 8'h40, 1'b1, 1'b0};
        vecs[11] = '{8'h20, 8'h00, 1, 8'h41, 8'h40, 1'b1, 1'b0};
        vecs[12] = '{8'h40, 8'h00, 1, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[13] = '{8'h40, 8'h00, 4, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[14] = '{8'h20, 8'h00, 1, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[15] = '{8'h02, 8'h00, 1, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[16] = '{8'h01, 8'h00, 1, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[17] = '{8'h01, 8'h00, 4, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[18] = '{8'h01, 8'h80, 0, 8'h80, 8'h00, 1'b1, 1'b0};
        vecs[19] = '{8'h01, 8'h00, 1, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[20] = '{8'h80, 8'h00, 1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[21] = '{8'h80, 8'h00, 4, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[22] = '{8'h10, 8'h20, 0, 8'h20, 8'h00, 1'b0, 1'b0};
        vecs[23] = '{8'h10, 8'h00, 1, 8'h20, 8'h20, 1'b1, 1'b0};
        vecs[24] = '{8'h20, 8'h00, 1, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[25] = '{8'h20, 8'h00, 4, 8'h00, 8'h00, 1'b1, 1'b0};

        rst       = 1'b1;
        btn       = 8'h00;
        cur_floor = 8'h01;
        tick      = 1'b0;
        cyc(3);
        chk8("reset_pending", pending, 8'h00);
        chk8("reset_target", target, 8'h00);
        chk1("reset_dir", dir_up, 1'b1);
        chk1("reset_door", door_open, 1'b0);
        chk1("reset_fault", fault, 1'b0);
        rst = 1'b0;
        cyc(4);

        // Table-driven scan walk.
        for (int i = 0; i < 26; i++) begin
            cur_floor = vecs[i].cur;
            if (vecs[i].btn != 8'h00) begin
                press(vecs[i].btn);
            end
            do_ticks(vecs[i].ticks);
            $display("[TB] vec %0d cur=%02h btn=%02h ticks=%0d -> pend=%02h tgt=%02h dir=%0b door=%0b",
                     i, vecs[i].cur, vecs[i].btn, vecs[i].ticks, pending, target, dir_up, door_open);
            chk8($sformatf("vec%0d_pending", i), pending, vecs[i].pend);
            chk8($sformatf("vec%0d_target", i), target, vecs[i].tgt);
            chk1($sformatf("vec%0d_dir", i), dir_up, vecs[i].dir);
            chk1($sformatf("vec%0d_door", i), door_open, vecs[i].door);
            chk1($sformatf("vec%0d_fault", i), fault, 1'b0);
        end

        // Re-press of the current floor during dwell restarts the dwell.
        cur_floor = 8'h04;
        press(8'h04);
        chk8("dwell_pend_set", pending, 8'h04);
        do_ticks(1);
        chk1("dwell_door_open", door_open, 1'b1);
        chk8("dwell_pend_clr", pending, 8'h00);
        do_ticks(2);
        press(8'h04);
        $display("[TB] dwell re-press cur=04 -> pend=%02h door=%0b", pending, door_open);
        chk8("dwell_repress_pend", pending, 8'h00);
        chk1("dwell_repress_door", door_open, 1'b1);
        do_ticks(3);
        chk1("dwell_after3_door", door_open, 1'b1);
        do_ticks(1);
        chk1("dwell_after4_door", door_open, 1'b0);
        chk8("dwell_after4_target", target, 8'h00);

        // Non-one-hot floor code on a tick: sticky fault, scheduling frozen.
        press(8'h80);
        do_ticks(1);
        chk8("fault_pre_target", target, 8'h80);
        cur_floor = 8'h06;
        do_ticks(1);
        $display("[TB] fault tick cur=06 -> fault=%0b tgt=%02h", fault, target);
        chk1("fault_set", fault, 1'b1);
        chk8("fault_hold_target", target, 8'h80);
        press(8'h01);
        chk8("fault_capture", pending, 8'h81);
        cur_floor = 8'h05;
        do_ticks(1);
        chk1("fault_hold_door", door_open, 1'b0);
        chk8("fault_hold_target2", target, 8'h80);
        cur_floor = 8'h04;
        do_ticks(1);
        chk1("fault_sticky", fault, 1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        $display("[TB] reset after fault -> fault=%0b pend=%02h", fault, pending);
        chk1("fault_rst_fault", fault, 1'b0);
        chk8("fault_rst_pending", pending, 8'h00);
        chk8("fault_rst_target", target, 8'h00);
        chk1("fault_rst_door", door_open, 1'b0);
        chk1("fault_rst_dir", dir_up, 1'b1);

        // Buttons held through reset release must not register.
        rst = 1'b1;
        btn = 8'hFF;
        cyc(2);
        rst = 1'b0;
        cyc(8);
        chk8("held_pending", pending, 8'h00);
        btn = 8'h00;
        cyc(6);
        chk8("released_pending", pending, 8'h00);
        btn = 8'h80;
        cyc(2);
        chk8("repress_early", pending, 8'h00);
        cyc(1);
        $display("[TB] re-press btn=80 -> pend=%02h", pending);
        chk8("repress_pending", pending, 8'h80);
        cyc(5);
        btn = 8'h00;
        chk8("repress_held_once", pending, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
